// File: rtl/mips_pkg.sv
// ----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the instruction-memory boot loader.
//   IMEM_AW        : instruction-memory word-address width (matches 10-bit PC count)
//   WORD_W         : instruction word width
//   loader_state_e : boot-loader FSM state encoding
// ----------------------------------------------------------------------------
package mips_pkg;

    localparam int unsigned IMEM_AW = 10;
    localparam int unsigned WORD_W  = 32;

    typedef enum logic [2:0] {
        StIdle,
        StLenHi,
        StLenLo,
        StData,
        StChk,
        StDone,
        StErr
    } loader_state_e;

endpackage

// File: rtl/imem_byte_packer.sv
// ----------------------------------------------------------------------------
// imem_byte_packer
// Packs a stream of bytes big-endian into 32-bit words (byte 0 -> bits [31:24]).
// Ports:
//   i_clk, i_reset   : clock, asynchronous active-low reset
//   i_clear          : synchronous clear of byte index, shift register and strobe
//   i_byte_valid     : a byte is consumed this cycle
//   i_byte_data      : byte being consumed
//   o_byte_last      : combinational; the byte consumed this cycle completes a word
//   o_word_valid     : registered; a complete word sits in o_word this cycle
//   o_word           : shift register contents (complete word when o_word_valid)
// ----------------------------------------------------------------------------
module imem_byte_packer
    import mips_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_clear,
    input  logic              i_byte_valid,
    input  logic [7:0]        i_byte_data,
    output logic              o_byte_last,
    output logic              o_word_valid,
    output logic [WORD_W-1:0] o_word
);

    logic [1:0]        r_idx;
    logic [WORD_W-1:0] r_shift;
    logic              r_word_valid;

    assign o_byte_last  = i_byte_valid && (r_idx == 2'd3);
    assign o_word_valid = r_word_valid;
    assign o_word       = r_shift;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_idx        <= 2'd0;
            r_shift      <= '0;
            r_word_valid <= 1'b0;
        end else if (i_clear) begin
            r_idx        <= 2'd0;
            r_shift      <= '0;
            r_word_valid <= 1'b0;
        end else begin
            // Strobe lags the 4th byte by one cycle, when the word is fully shifted in.
            r_word_valid <= o_byte_last;
            if (i_byte_valid) begin
                r_idx   <= r_idx + 2'd1;
                r_shift <= {r_shift[WORD_W-9:0], i_byte_data};
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// ----------------------------------------------------------------------------
// imem_loader
// Boot-time writer for the instruction memory. Receives a frame over a byte
// valid/ready handshake: LEN_HI, LEN_LO (word count N), 4*N data bytes packed
// big-endian into words written to addresses 0..N-1. Holds the CPU until the
// image is fully written.
// Optional feature macro: CHECKSUM_EN -- a trailing byte equal to the XOR of all
// data bytes must follow the data; mismatch ends in the error state.
// Ports:
//   i_clk, i_reset   : clock, asynchronous active-low reset
//   i_start          : 1-cycle pulse starting a load (honoured in idle/done/error)
//   i_byte_valid     : host byte available
//   i_byte_data      : host byte
//   o_byte_ready     : loader accepts a byte (transfer = valid & ready)
//   o_imem_we        : 1-cycle instruction-memory write strobe
//   o_imem_addr      : word address for o_imem_we
//   o_imem_wdata     : word for o_imem_we
//   o_cpu_hold       : 1 = CPU pipeline held
//   o_load_done      : image written successfully (level)
//   o_load_err       : length or checksum failure (level)
//   o_word_count     : words written in the current load
// ----------------------------------------------------------------------------
module imem_loader
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W    = IMEM_AW,
    parameter bit          BOOT_HOLD = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_byte_valid,
    input  logic [7:0]        i_byte_data,
    output logic              o_byte_ready,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [WORD_W-1:0] o_imem_wdata,
    output logic              o_cpu_hold,
    output logic              o_load_done,
    output logic              o_load_err,
    output logic [ADDR_W:0]   o_word_count
);

    // Image length limit; derived from the address width, never overridden.
    localparam int unsigned     DEPTH  = 1 << ADDR_W;
    localparam logic [ADDR_W:0] CntOne = 1;

    loader_state_e     r_state;
    loader_state_e     w_state_next;
    logic [7:0]        r_len_hi;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_count;
    logic [15:0]       w_len;
    logic              w_len_ok;
    logic              w_clear;
    logic              w_pack_valid;
    logic              w_byte_last;
    logic              w_word_valid;
    logic              w_last_word;
    logic [WORD_W-1:0] w_word;

`ifdef CHECKSUM_EN
    logic [7:0]        r_csum;
`endif

    // Length as seen while LEN_LO is on the bus.
    assign w_len    = {r_len_hi, i_byte_data};
    assign w_len_ok = (w_len != 16'd0) && (32'(w_len) <= DEPTH);

    assign o_byte_ready = (r_state == StLenHi) || (r_state == StLenLo) ||
                          (r_state == StData)  || (r_state == StChk);

    assign w_pack_valid = (r_state == StData) && i_byte_valid;

    // r_count still holds the index of the word being assembled: the previous
    // word's increment lands at least two cycles before the next 4th byte.
    assign w_last_word = w_byte_last && ((r_count + CntOne) == r_len);

    imem_byte_packer u_packer (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_clear      (w_clear),
        .i_byte_valid (w_pack_valid),
        .i_byte_data  (i_byte_data),
        .o_byte_last  (w_byte_last),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        unique case (r_state)
            StIdle, StDone, StErr: begin
                if (i_start) begin
                    w_state_next = StLenHi;
                    w_clear      = 1'b1;
                end
            end
            StLenHi: begin
                if (i_byte_valid) begin
                    w_state_next = StLenLo;
                end
            end
            StLenLo: begin
                if (i_byte_valid) begin
                    w_state_next = w_len_ok ? StData : StErr;
                end
            end
            StData: begin
                if (w_last_word) begin
`ifdef CHECKSUM_EN
                    w_state_next = StChk;
`else
                    w_state_next = StDone;
`endif
                end
            end
`ifdef CHECKSUM_EN
            StChk: begin
                if (i_byte_valid) begin
                    w_state_next = (i_byte_data == r_csum) ? StDone : StErr;
                end
            end
`endif
            default: begin
                w_state_next = StErr;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_len_hi <= 8'd0;
            r_len    <= '0;
        end else begin
            if ((r_state == StLenHi) && i_byte_valid) begin
                r_len_hi <= i_byte_data;
            end
            if ((r_state == StLenLo) && i_byte_valid) begin
                r_len <= w_len[ADDR_W:0];
            end
        end
    end

    // Word counter doubles as the write address; it advances as each write fires.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_count <= '0;
        end else if (w_clear) begin
            r_count <= '0;
        end else if (w_word_valid) begin
            r_count <= r_count + CntOne;
        end
    end

`ifdef CHECKSUM_EN
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_csum <= 8'd0;
        end else if (w_clear) begin
            r_csum <= 8'd0;
        end else if (w_pack_valid) begin
            r_csum <= r_csum ^ i_byte_data;
        end
    end
`endif

    assign o_imem_we    = w_word_valid;
    assign o_imem_addr  = r_count[ADDR_W-1:0];
    assign o_imem_wdata = w_word;
    assign o_word_count = r_count;

    // DONE is entered while the final write is still on the bus; completion and
    // CPU release wait one more cycle so release always follows that write.
    assign o_load_done = (r_state == StDone) && !w_word_valid;
    assign o_load_err  = (r_state == StErr);

    always_comb begin
        o_cpu_hold = 1'b1;
        if (r_state == StIdle) begin
            o_cpu_hold = BOOT_HOLD;
        end else if (r_state == StDone) begin
            o_cpu_hold = w_word_valid;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// ----------------------------------------------------------------------------
// tb_imem_loader
// Self-checking bench for imem_loader: a table of frames with expected
// outcomes, plus hand-written sequences for reset and (with CHECKSUM_EN) a bad
// checksum.
// ----------------------------------------------------------------------------
module tb_imem_loader;

    localparam int unsigned ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = 8'd0;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              load_done;
    logic              load_err;
    logic [ADDR_W:0]   word_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [ADDR_W-1:0] wr_addr[$];
    logic [31:0]       wr_data[$];

    typedef struct {
        string       name;
        logic [15:0] len;
        int          nsend;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        int          gap;      // -1: random 0..3 idle cycles before each byte
        bit          exp_done;
    } vec_t;

    vec_t vecs[6];

    imem_loader #(
        .ADDR_W    (ADDR_W),
        .BOOT_HOLD (1'b1)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_start      (start),
        .i_byte_valid (byte_valid),
        .i_byte_data  (byte_data),
        .o_byte_ready (byte_ready),
        .o_imem_we    (imem_we),
        .o_imem_addr  (imem_addr),
        .o_imem_wdata (imem_wdata),
        .o_cpu_hold   (cpu_hold),
        .o_load_done  (load_done),
        .o_load_err   (load_err),
        .o_word_count (word_count)
    );

    always #5 clk = ~clk;

    // Write log, sampled away from the active edge.
    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input vec_t v, input int i);
        logic [31:0] idx;
        idx = i;
        if (i == 0) return v.w0;
        if (i == 1) return v.w1;
        if (i == 2) return v.w2;
        return {idx[15:0], ~idx[15:0]};
    endfunction

    function automatic int pick_gap(input int g);
        if (g < 0) return int'($urandom_range(0, 3));
        return g;
    endfunction

    // Entered and left on a falling edge; the transfer happens on the rising
    // edge in between once byte_ready is seen.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        waited = 0;
        byte_valid = 1'b0;
        repeat (gap) @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!byte_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL byte_ready_timeout: actual 0 expected 1 (byte %0h)", b);
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        logic [31:0] w;
        int          nexp;
        int          nbad;
`ifdef CHECKSUM_EN
        logic [7:0]  csum;
        csum = 8'd0;
`endif
        wr_addr.delete();
        wr_data.delete();
        nexp = v.exp_done ? v.nsend : 0;
        pulse_start();
        send_byte(v.len[15:8], pick_gap(v.gap));
        send_byte(v.len[7:0], pick_gap(v.gap));
        for (int i = 0; i < v.nsend; i++) begin
            w = word_of(v, i);
            for (int k = 0; k < 4; k++) begin
`ifdef CHECKSUM_EN
                csum = csum ^ w[31-8*k -: 8];
`endif
                send_byte(w[31-8*k -: 8], pick_gap(v.gap));
            end
        end
`ifdef CHECKSUM_EN
        if (v.exp_done) send_byte(csum, pick_gap(v.gap));
`else
        if (v.exp_done) begin
            // Final write is on the bus now; CPU must still be held.
            check($sformatf("%s:last_we", v.name), 32'(imem_we), 32'd1);
            check($sformatf("%s:hold_during_last_we", v.name), 32'(cpu_hold), 32'd1);
        end
`endif
        @(negedge clk);
        check($sformatf("%s:load_done", v.name), 32'(load_done), 32'(v.exp_done));
        check($sformatf("%s:load_err", v.name), 32'(load_err), 32'(!v.exp_done));
        check($sformatf("%s:cpu_hold", v.name), 32'(cpu_hold), 32'(!v.exp_done));
        check($sformatf("%s:byte_ready", v.name), 32'(byte_ready), 32'd0);
        check($sformatf("%s:word_count", v.name), 32'(word_count), nexp);
        check($sformatf("%s:write_count", v.name), wr_addr.size(), nexp);
        nbad = 0;
        for (int i = 0; i < wr_addr.size() && i < nexp; i++) begin
            if (wr_addr[i] !== ADDR_W'(i) || wr_data[i] !== word_of(v, i)) begin
                if (nbad == 0)
                    $display("write %0d: addr %0h data %0h, model addr %0h data %0h",
                             i, wr_addr[i], wr_data[i], i, word_of(v, i));
                nbad++;
            end
        end
        check($sformatf("%s:write_mismatches", v.name), nbad, 32'd0);
    endtask

    initial begin
        vecs[0] = '{"two_words", 16'h0002, 2, 32'h24080005, 32'h0000000C, 32'h0, 0, 1'b1};
        vecs[1] = '{"len_zero", 16'h0000, 0, 32'h0, 32'h0, 32'h0, 0, 1'b0};
        vecs[2] = '{"len_1025", 16'h0401, 0, 32'h0, 32'h0, 32'h0, 0, 1'b0};
        vecs[3] = '{"one_word", 16'h0001, 1, 32'hDEADBEEF, 32'h0, 32'h0, 0, 1'b1};
        vecs[4] = '{"gaps_three", 16'h0003, 3, 32'h01020304, 32'hA5A55A5A, 32'hFFFFFFFF,
                    -1, 1'b1};
        vecs[5] = '{"full_depth", 16'h0400, 1024, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F,
                    0, 1'b1};

        // Reset release without start.
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("reset:cpu_hold", 32'(cpu_hold), 32'd1);
        check("reset:byte_ready", 32'(byte_ready), 32'd0);
        check("reset:load_done", 32'(load_done), 32'd0);
        check("reset:load_err", 32'(load_err), 32'd0);
        check("reset:word_count", 32'(word_count), 32'd0);
        check("reset:imem_addr", 32'(imem_addr), 32'd0);
        check("reset:imem_wdata", imem_wdata, 32'd0);
        check("reset:writes", wr_addr.size(), 32'd0);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
        end

`ifdef CHECKSUM_EN
        // Bad checksum: error, but the word is already in memory.
        wr_addr.delete();
        wr_data.delete();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        send_byte(8'h45, 0);
        @(negedge clk);
        check("bad_csum:load_err", 32'(load_err), 32'd1);
        check("bad_csum:load_done", 32'(load_done), 32'd0);
        check("bad_csum:cpu_hold", 32'(cpu_hold), 32'd1);
        check("bad_csum:write_count", wr_addr.size(), 32'd1);
        if (wr_data.size() > 0) check("bad_csum:word0", wr_data[0], 32'h11223344);
`endif

        // Asynchronous reset after 6 data bytes of a 2-word frame.
        wr_addr.delete();
        wr_data.delete();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        for (int k = 0; k < 6; k++) send_byte(8'h10 + 8'(k), 0);
        check("abort:word_count_before", 32'(word_count), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort:byte_ready", 32'(byte_ready), 32'd0);
        check("abort:imem_we", 32'(imem_we), 32'd0);
        check("abort:cpu_hold", 32'(cpu_hold), 32'd1);
        check("abort:word_count", 32'(word_count), 32'd0);
        check("abort:imem_addr", 32'(imem_addr), 32'd0);
        check("abort:imem_wdata", imem_wdata, 32'd0);
        byte_valid = 1'b1;
        byte_data  = 8'h16;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        byte_valid = 1'b0;
        check("abort:writes", wr_addr.size(), 32'd1);
        check("abort:idle_ready", 32'(byte_ready), 32'd0);
        check("abort:load_done", 32'(load_done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
